agu_k2_wb_ctrl: RTL and testbench
=================================

// Module: agu_k2_wb_ctrl
// PURPOSE
// - Write-back consumer of the k2-stage AGU address stream. Captures each {Order_0, Order_1} pair
//   when the AGU asserts its output enable, and holds it in an address FIFO.
// - Pairs each queued address pair, in order, with the next butterfly result and issues a
//   dual-port memory write.
// - Sits between AGU_k2 / butterfly outputs and the coefficient memory banks; reports stage done.
// PARAMETERS
// - D_WIDTH     32  address/index width (= `D_width)
// - DATA_W      64  coefficient width per butterfly output
// - FIFO_DEPTH  8   address-pair FIFO entries; power of 2, >= max butterfly latency + 2
// PORTS
// - clk           in   1        clock
// - rst           in   1        reset, asynchronous, active-high
// - addr_en_i     in   1        address pair valid (from AGU_out_en_k2)
// - order0_i      in   D_WIDTH  even address (from Order_0_k2)
// - order1_i      in   D_WIDTH  odd address (from Order_1_k2)
// - agu_done_i    in   1        AGU stage-complete pulse (from AGU_done_k2)
// - bf_valid_i    in   1        butterfly result valid
// - bf_data0_i    in   DATA_W   butterfly output 0
// - bf_data1_i    in   DATA_W   butterfly output 1
// - mem_we_o      out  1        memory write strobe
// - mem_addr0_o   out  D_WIDTH  write address, port 0
// - mem_addr1_o   out  D_WIDTH  write address, port 1
// - mem_wdata0_o  out  DATA_W    write data, port 0
// - mem_wdata1_o  out  DATA_W    write data, port 1
// - fifo_full_o   out  1        FIFO holds FIFO_DEPTH entries
// - fifo_empty_o  out  1        FIFO holds 0 entries
// - wb_cnt_o      out  D_WIDTH  pairs written since leaving IDLE
// - wb_done_o     out  1        one-cycle stage write-back complete pulse
// - ovf_err_o     out  1        sticky: push while full without simultaneous pop
// - udf_err_o     out  1        sticky: bf_valid_i while FIFO empty
// - pair_err_o    out  1        sticky: pair-check failure (optional feature)
// BEHAVIOUR
// - Reset values:
//   - all outputs 0, except fifo_empty_o = 1;
//   - FIFO pointers 0; state IDLE.
// - FIFO:
//   - push when addr_en_i = 1 in state RUN or DRAIN, or in IDLE (the push itself moves IDLE to RUN);
//   - pop when bf_valid_i = 1 and the FIFO is non-empty;
//   - pointers wrap modulo FIFO_DEPTH; occupancy counter is width clog2(FIFO_DEPTH)+1.
// - Simultaneous push and pop:
//   - allowed at any occupancy, including full;
//   - occupancy unchanged, no error.
// - Push while full without pop:
//   - entry dropped, FIFO unchanged;
//   - ovf_err_o = 1 from the next cycle.
// - Pop while empty:
//   - no write issued;
//   - udf_err_o = 1 from the next cycle.
// - Write path (latency 1, registered):
//   - a pop at cycle N gives mem_we_o = 1 at cycle N+1;
//   - at N+1, addr0/addr1 = head entry, wdata0/1 = bf_data0/1_i sampled at N;
//   - mem_we_o = 0 otherwise; addr/data outputs hold their last values.
// - wb_cnt_o:
//   - +1 per issued write, wraps at 2^D_WIDTH;
//   - cleared on the IDLE->RUN transition.
// - Error flags ovf/udf/pair clear only on rst.
// - FSM:
//   - IDLE: on addr_en_i -> RUN.
//   - RUN: on agu_done_i -> DRAIN. agu_done_i in IDLE is ignored.
//   - DRAIN: pushes still accepted, since the AGU output enable lags done by one cycle.
//     When FIFO is empty, and addr_en_i = 0, and bf_valid_i = 0 -> DONE.
//   - DONE: wb_done_o = 1 for exactly this cycle -> IDLE.
//     addr_en_i in DONE is pushed, and the next state is RUN instead of IDLE.
// - Reset mid-operation:
//   - FIFO contents discarded, FSM to IDLE;
//   - no write is issued in the cycle after reset deasserts.
// - Addresses are stored verbatim, with no bit-reversal or arithmetic applied.
// CONFIGURATION
// - Macro WB_PAIR_CHECK_EN.
// - Defined: on every accepted push, if order1_i != order0_i + 1 (mod 2^D_WIDTH), pair_err_o = 1
//   (sticky) from the next cycle. The pair is still queued.
// - Undefined: no check logic; pair_err_o tied 0.
// TESTING
// - Stream: 4 pushes (0/1, 2/3, 4/5, 6/7), then 4 bf_valid with data 0xA0..0xA3 / 0xB0..0xB3
//   -> 4 writes in order, each 1 cycle after its bf_valid; addr0 = 0,2,4,6; wb_cnt_o = 4.
// - Done: agu_done_i at push 4, then one trailing push, then 5 pops -> DRAIN, then DONE;
//   wb_done_o is a 1-cycle pulse one cycle after the FIFO empties; wb_cnt_o = 5.
// - Full: 8 pushes, then a 9th push without pop -> fifo_full_o = 1, ovf_err_o = 1, 8 writes drain.
//   Repeat with the 9th push plus a simultaneous pop -> no ovf_err_o.
// - Empty: bf_valid_i with FIFO empty -> udf_err_o = 1, mem_we_o stays 0.
// - Reset: assert rst with 3 entries queued -> fifo_empty_o = 1, state IDLE, no writes; a new
//   stream after reset restarts wb_cnt_o at 1.
// - WB_PAIR_CHECK_EN defined: push 4/6 -> pair_err_o = 1; push 4/5 -> pair_err_o stays 0.
//   Undefined: push 4/6 -> pair_err_o stays 0.

Source files
------------

// File: rtl/agu_k2_wb_ctrl.sv
// agu_k2_wb_ctrl
// Write-back consumer of the k2-stage AGU address stream. Each {order0, order1}
// pair offered by the AGU is queued in a small FIFO. Each butterfly result is
// paired, in order, with the oldest queued pair and written to the coefficient
// memory through a registered dual-port write. Stage completion is reported
// once the AGU has finished and every queued pair has been written.
//
// Ports
//   clk, rst                     clock; asynchronous active-high reset
//   addr_en_i, order0_i/1_i      AGU address pair and its valid
//   agu_done_i                   AGU stage-complete pulse
//   bf_valid_i, bf_data0_i/1_i   butterfly result and its valid
//   mem_we_o, mem_addr0/1_o,
//   mem_wdata0/1_o               registered memory write port (latency 1)
//   fifo_full_o, fifo_empty_o    address FIFO status
//   wb_cnt_o                     pairs written since leaving IDLE
//   wb_done_o                    one-cycle stage-complete pulse
//   ovf_err_o, udf_err_o,
//   pair_err_o                   sticky error flags, cleared only by rst
//   dbg_state_o                  FSM state: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
//
// Handshake: addr_en_i and bf_valid_i are single-cycle valid strobes with no
// ready/back-pressure. A pair is accepted when addr_en_i is high and the FIFO
// is not full (or is popped in the same cycle); a butterfly result consumes the
// head pair when bf_valid_i is high and the FIFO is not empty. Anything not
// accepted is dropped and flagged.
//
// Configuration
//   WB_PAIR_CHECK_EN  when defined, every accepted pair must satisfy
//                     order1 == order0 + 1; otherwise pair_err_o is set.
//                     When undefined, pair_err_o is tied low.

module agu_k2_wb_ctrl #(
  parameter int D_WIDTH    = 32,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 8    // power of 2, >= 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               addr_en_i,
  input  logic [D_WIDTH-1:0] order0_i,
  input  logic [D_WIDTH-1:0] order1_i,
  input  logic               agu_done_i,
  input  logic               bf_valid_i,
  input  logic [DATA_W-1:0]  bf_data0_i,
  input  logic [DATA_W-1:0]  bf_data1_i,
  output logic               mem_we_o,
  output logic [D_WIDTH-1:0] mem_addr0_o,
  output logic [D_WIDTH-1:0] mem_addr1_o,
  output logic [DATA_W-1:0]  mem_wdata0_o,
  output logic [DATA_W-1:0]  mem_wdata1_o,
  output logic               fifo_full_o,
  output logic               fifo_empty_o,
  output logic [D_WIDTH-1:0] wb_cnt_o,
  output logic               wb_done_o,
  output logic               ovf_err_o,
  output logic               udf_err_o,
  output logic               pair_err_o,
  output logic [1:0]         dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   enter_run;

  // ---------------------------------------------------------------- FIFO
  logic [D_WIDTH-1:0] fifo_a0 [FIFO_DEPTH];
  logic [D_WIDTH-1:0] fifo_a1 [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      occ;
  logic               push, pop;

  assign fifo_empty_o = (occ == '0);
  assign fifo_full_o  = (occ == FULL_CNT);

  assign pop  = bf_valid_i && !fifo_empty_o;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign push = addr_en_i && (!fifo_full_o || pop);

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a0[wr_ptr] <= order0_i;
      fifo_a1[wr_ptr] <= order1_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    enter_run = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (addr_en_i) begin
          state_d   = S_RUN;
          enter_run = 1'b1;
        end
      end
      S_RUN: begin
        if (agu_done_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // The AGU enable trails its done pulse, so keep accepting pushes and
        // only finish once nothing is queued or arriving.
        if (fifo_empty_o && !addr_en_i && !bf_valid_i) state_d = S_DONE;
      end
      S_DONE: begin
        // A push in DONE opens the next stage straight away; the count is
        // not cleared because the block never passed through IDLE.
        state_d = addr_en_i ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wb_done_o   = (state_q == S_DONE);
  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------- write path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_o     <= 1'b0;
      mem_addr0_o  <= '0;
      mem_addr1_o  <= '0;
      mem_wdata0_o <= '0;
      mem_wdata1_o <= '0;
    end else begin
      mem_we_o <= pop;
      if (pop) begin
        mem_addr0_o  <= fifo_a0[rd_ptr];
        mem_addr1_o  <= fifo_a1[rd_ptr];
        mem_wdata0_o <= bf_data0_i;
        mem_wdata1_o <= bf_data1_i;
      end
    end
  end

  // Counter moves on the same edge that raises mem_we_o, so the count already
  // includes the write being presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cnt_o <= '0;
    end else if (enter_run) begin
      wb_cnt_o <= {{(D_WIDTH-1){1'b0}}, pop};
    end else if (pop) begin
      wb_cnt_o <= wb_cnt_o + D_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------- errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err_o <= 1'b0;
      udf_err_o <= 1'b0;
    end else begin
      if (addr_en_i && fifo_full_o && !pop) ovf_err_o <= 1'b1;
      if (bf_valid_i && fifo_empty_o)       udf_err_o <= 1'b1;
    end
  end

`ifdef WB_PAIR_CHECK_EN
  logic [D_WIDTH-1:0] order0_inc;
  assign order0_inc = order0_i + D_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  pair_err_o <= 1'b0;
    else if (push && (order1_i != order0_inc)) pair_err_o <= 1'b1;
  end
`else
  assign pair_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_agu_k2_wb_ctrl.sv
// tb_agu_k2_wb_ctrl
// Bench for agu_k2_wb_ctrl: directed scenarios with literal expectations,
// then a randomized run. A queue-based reference model is advanced on every
// rising edge and all DUT outputs are compared against it shortly after.

module tb_agu_k2_wb_ctrl;

  localparam int DW    = 32;
  localparam int XW    = 64;
  localparam int DEPTH = 8;

  // model phases
  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          addr_en_i = 1'b0;
  logic [DW-1:0] order0_i = '0, order1_i = '0;
  logic          agu_done_i = 1'b0;
  logic          bf_valid_i = 1'b0;
  logic [XW-1:0] bf_data0_i = '0, bf_data1_i = '0;
  logic          mem_we_o;
  logic [DW-1:0] mem_addr0_o, mem_addr1_o;
  logic [XW-1:0] mem_wdata0_o, mem_wdata1_o;
  logic          fifo_full_o, fifo_empty_o;
  logic [DW-1:0] wb_cnt_o;
  logic          wb_done_o, ovf_err_o, udf_err_o, pair_err_o;
  logic [1:0]    dbg_state_o;

  agu_k2_wb_ctrl #(.D_WIDTH(DW), .DATA_W(XW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .addr_en_i(addr_en_i), .order0_i(order0_i), .order1_i(order1_i),
    .agu_done_i(agu_done_i),
    .bf_valid_i(bf_valid_i), .bf_data0_i(bf_data0_i), .bf_data1_i(bf_data1_i),
    .mem_we_o(mem_we_o), .mem_addr0_o(mem_addr0_o), .mem_addr1_o(mem_addr1_o),
    .mem_wdata0_o(mem_wdata0_o), .mem_wdata1_o(mem_wdata1_o),
    .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o),
    .wb_cnt_o(wb_cnt_o), .wb_done_o(wb_done_o),
    .ovf_err_o(ovf_err_o), .udf_err_o(udf_err_o), .pair_err_o(pair_err_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- bookkeeping
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef WB_PAIR_CHECK_EN
  localparam bit PAIR_CHECK = 1'b1;
`else
  localparam bit PAIR_CHECK = 1'b0;
`endif

  // ---------------------------------------------------------------- reference model
  logic [2*DW-1:0] exp_q[$];          // queued {order1, order0}
  int              m_phase;
  logic            e_we;
  logic [DW-1:0]   e_a0, e_a1, e_cnt;
  logic [XW-1:0]   e_d0, e_d1;
  logic            e_ovf, e_udf, e_pair;

  logic [DW-1:0]   wr_log[$];         // addr0 of every observed write
  int              done_pulses = 0;

  task automatic model_reset();
    exp_q.delete();
    m_phase = P_IDLE;
    e_we = 1'b0; e_a0 = '0; e_a1 = '0; e_d0 = '0; e_d1 = '0; e_cnt = '0;
    e_ovf = 1'b0; e_udf = 1'b0; e_pair = 1'b0;
  endtask

  task automatic model_step(input logic a, input logic [DW-1:0] o0, input logic [DW-1:0] o1,
                            input logic dn, input logic v,
                            input logic [XW-1:0] d0, input logic [XW-1:0] d1);
    int  n;
    bit  take, keep;
    logic [2*DW-1:0] head;
    n    = exp_q.size();
    take = v && (n > 0);
    keep = a && ((n < DEPTH) || take);
    if (v && n == 0)                  e_udf = 1'b1;
    if (a && n == DEPTH && !take)     e_ovf = 1'b1;
    if (PAIR_CHECK && keep && (o1 != o0 + 1)) e_pair = 1'b1;

    if (m_phase == P_IDLE && a) e_cnt = '0;
    e_we = take;
    if (take) begin
      head  = exp_q.pop_front();
      e_a0  = head[DW-1:0];
      e_a1  = head[2*DW-1:DW];
      e_d0  = d0;
      e_d1  = d1;
      e_cnt = e_cnt + 1;
    end
    if (keep) exp_q.push_back({o1, o0});

    if (m_phase == P_IDLE) begin
      if (a) m_phase = P_RUN;
    end else if (m_phase == P_RUN) begin
      if (dn) m_phase = P_DRAIN;
    end else if (m_phase == P_DRAIN) begin
      if (n == 0 && !a && !v) m_phase = P_DONE;
    end else begin
      m_phase = a ? P_RUN : P_IDLE;
    end
  endtask

  // Single compare process: advance model on each rising edge, check 1 ns later.
  initial begin
    logic          s_rst, s_a, s_dn, s_v;
    logic [DW-1:0] s_o0, s_o1;
    logic [XW-1:0] s_d0, s_d1;
    model_reset();
    forever begin
      @(posedge clk);
      s_rst = rst; s_a = addr_en_i; s_o0 = order0_i; s_o1 = order1_i;
      s_dn = agu_done_i; s_v = bf_valid_i; s_d0 = bf_data0_i; s_d1 = bf_data1_i;
      if (s_rst) model_reset();
      else       model_step(s_a, s_o0, s_o1, s_dn, s_v, s_d0, s_d1);
      #1;
      chk("mem_we", mem_we_o, e_we);
      chk("addr0", mem_addr0_o, e_a0);
      chk("addr1", mem_addr1_o, e_a1);
      chk("wdata0", mem_wdata0_o, e_d0);
      chk("wdata1", mem_wdata1_o, e_d1);
      chk("full", fifo_full_o, exp_q.size() == DEPTH);
      chk("empty", fifo_empty_o, exp_q.size() == 0);
      chk("wb_cnt", wb_cnt_o, e_cnt);
      chk("wb_done", wb_done_o, m_phase == P_DONE);
      chk("ovf", ovf_err_o, e_ovf);
      chk("udf", udf_err_o, e_udf);
      chk("pair", pair_err_o, e_pair);
      chk("state", dbg_state_o, m_phase);
      if (mem_we_o)  wr_log.push_back(mem_addr0_o);
      if (wb_done_o) done_pulses++;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic drive(input logic a, input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                       input logic dn, input logic v,
                       input logic [XW-1:0] y0, input logic [XW-1:0] y1);
    @(negedge clk);
    addr_en_i = a; order0_i = x0; order1_i = x1; agu_done_i = dn;
    bf_valid_i = v; bf_data0_i = y0; bf_data1_i = y1;
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic push(input logic [DW-1:0] x0, input logic [DW-1:0] x1, input logic dn);
    drive(1'b1, x0, x1, dn, 1'b0, '0, '0);
  endtask

  task automatic pop(input logic [XW-1:0] y0, input logic [XW-1:0] y1);
    drive(1'b0, '0, '0, 1'b0, 1'b1, y0, y1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    addr_en_i = 1'b0; agu_done_i = 1'b0; bf_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] log_at(input int i);
    return (i < wr_log.size()) ? wr_log[i] : '1;
  endfunction

  // ---------------------------------------------------------------- scenarios
  initial begin
    @(negedge clk);
    @(negedge clk);
    // reset state
    chk("rst_empty", fifo_empty_o, 1'b1);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_cnt", wb_cnt_o, 0);
    rst = 1'b0;

    // stream: 4 pairs then 4 results
    wr_log.delete();
    for (int i = 0; i < 4; i++) push(2*i, 2*i+1, 1'b0);
    for (int i = 0; i < 4; i++) pop(64'hA0 + i, 64'hB0 + i);
    idle_cyc(2);
    chk("stream_nwr", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("stream_addr0", log_at(i), 2*i);
    chk("stream_cnt", wb_cnt_o, 4);
    chk("stream_d0", mem_wdata0_o, 64'hA3);
    chk("stream_d1", mem_wdata1_o, 64'hB3);
    chk("stream_a1", mem_addr1_o, 7);

    // done: agu_done with 4th push, trailing push, 5 results
    do_reset();
    wr_log.delete();
    done_pulses = 0;
    for (int i = 0; i < 4; i++) push(2*i, 2*i+1, i == 3);
    push(8, 9, 1'b0);
    chk("done_drain", dbg_state_o, 2);
    for (int i = 0; i < 5; i++) pop(64'hC0 + i, 64'hD0 + i);
    idle_cyc(5);
    chk("done_pulses", done_pulses, 1);
    chk("done_cnt", wb_cnt_o, 5);
    chk("done_idle", dbg_state_o, 0);

    // full: 9th push without pop overflows
    do_reset();
    wr_log.delete();
    for (int i = 0; i < 8; i++) push(2*i, 2*i+1, 1'b0);
    idle_cyc(1);
    chk("full_flag", fifo_full_o, 1'b1);
    push(100, 101, 1'b0);
    idle_cyc(1);
    chk("full_ovf", ovf_err_o, 1'b1);
    for (int i = 0; i < 8; i++) pop(i, i);
    idle_cyc(2);
    chk("full_nwr", wr_log.size(), 8);
    chk("full_last", log_at(7), 14);
    chk("full_drained", fifo_empty_o, 1'b1);

    // full with simultaneous pop: no overflow
    do_reset();
    wr_log.delete();
    for (int i = 0; i < 8; i++) push(2*i, 2*i+1, 1'b0);
    drive(1'b1, 100, 101, 1'b0, 1'b1, 64'h55, 64'h66);
    idle_cyc(1);
    chk("fullpp_ovf", ovf_err_o, 1'b0);
    chk("fullpp_full", fifo_full_o, 1'b1);
    for (int i = 0; i < 8; i++) pop(i, i);
    idle_cyc(2);
    chk("fullpp_nwr", wr_log.size(), 9);
    chk("fullpp_last", log_at(8), 100);

    // empty: result with nothing queued
    do_reset();
    wr_log.delete();
    pop(64'h1, 64'h2);
    idle_cyc(2);
    chk("empty_udf", udf_err_o, 1'b1);
    chk("empty_nwr", wr_log.size(), 0);

    // reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++) push(2*i, 2*i+1, 1'b0);
    wr_log.delete();
    do_reset();
    chk("rstmid_empty", fifo_empty_o, 1'b1);
    chk("rstmid_state", dbg_state_o, 0);
    chk("rstmid_we", mem_we_o, 1'b0);
    push(10, 11, 1'b0);
    pop(64'h7, 64'h8);
    idle_cyc(2);
    chk("rstmid_nwr", wr_log.size(), 1);
    chk("rstmid_cnt", wb_cnt_o, 1);

    // pair check
    do_reset();
    push(4, 5, 1'b0);
    idle_cyc(1);
    chk("pair_ok", pair_err_o, 1'b0);
    push(4, 6, 1'b0);
    idle_cyc(1);
    chk("pair_bad", pair_err_o, PAIR_CHECK);

    // randomized run
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        logic [DW-1:0] r0, r1;
        r0 = $urandom;
        r1 = ($urandom_range(0, 7) == 0) ? DW'($urandom) : r0 + 1;
        drive($urandom_range(0, 99) < 50, r0, r1,
              $urandom_range(0, 29) == 0, $urandom_range(0, 99) < 48,
              {$urandom, $urandom}, {$urandom, $urandom});
      end
    end
    idle_cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
